// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: redirect, instruction-memory and decode-side signals of the fetch sequencer.
// Latency: none, wiring only.
// Backpressure: imem_gnt throttles requests and instr_ready throttles delivery to decode.
interface ifu_fetch_if #(
    parameter int XLEN      = 32,
    parameter int INSTR_LEN = 32
);
    logic [XLEN-1:0]      pc_in;
    logic                 pc_load;
    logic                 imem_req;
    logic [XLEN-1:0]      imem_addr;
    logic                 imem_gnt;
    logic                 imem_rvalid;
    logic [INSTR_LEN-1:0] imem_rdata;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_LEN-1:0] instr_out;
    logic [XLEN-1:0]      instr_tag_out;

    modport master (
        input  pc_in, pc_load, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output imem_req, imem_addr, instr_valid, instr_out, instr_tag_out
    );

    modport slave (
        output pc_in, pc_load, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  imem_req, imem_addr, instr_valid, instr_out, instr_tag_out
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC sequencer with in-order imem requests and tagged output buffer (option IFU_BYPASS_EN).
// Latency: rvalid->instr_valid 1 cycle (0 with IFU_BYPASS_EN when buffer is empty); pc_load->new-PC request next cycle.
// Backpressure: at most DEPTH fetches in flight plus buffered; imem_req drops when those credits run out.
module ifu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module ifu_fetch #(
    parameter int              XLEN      = 32,
    parameter int              INSTR_LEN = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              DEPTH     = 2
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master bus
);
    localparam int              STEP       = INSTR_LEN / 8;
    localparam int              CW         = $clog2(DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(STEP) - XLEN'(1));

    typedef enum logic {BOOT, RUN} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic                      fetch_req;
    logic                      grant;
    logic                      keep_rsp;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [XLEN-1:0]           fetch_pc;
    logic [XLEN-1:0]           rsp_tag;
    logic [CW-1:0]             outstanding;
    logic [CW-1:0]             fifo_count;
    logic [CW-1:0]             discard_cnt;
    logic [INSTR_LEN+XLEN-1:0] fifo_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fetch_req = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (!bus.pc_load && (int'(outstanding) + int'(fifo_count) < DEPTH))
                    fetch_req = 1'b1;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign grant         = fetch_req & bus.imem_gnt;
    assign bus.imem_req  = fetch_req;
    assign bus.imem_addr = fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              fetch_pc <= RESET_PC;
        else if (bus.pc_load) fetch_pc <= bus.pc_in & ALIGN_MASK;
        else if (grant)       fetch_pc <= fetch_pc + XLEN'(STEP);
    end

    // Stale responses still in flight at a redirect are counted here and dropped as they return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            discard_cnt <= '0;
        else if (bus.pc_load)
            discard_cnt <= discard_cnt + outstanding - CW'(bus.imem_rvalid);
        else if (bus.imem_rvalid && discard_cnt != '0)
            discard_cnt <= discard_cnt - CW'(1);
    end

    // The tag queue occupancy is the in-flight request count.
    ifu_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (grant),
        .push_dat (fetch_pc),
        .pop      (bus.imem_rvalid),
        .head_dat (rsp_tag),
        .count    (outstanding)
    );

    assign keep_rsp = bus.imem_rvalid & ~bus.pc_load & (discard_cnt == '0);
    assign fifo_pop = (fifo_count != '0) & bus.instr_ready;

`ifdef IFU_BYPASS_EN
    logic bypass;
    assign bypass            = keep_rsp & (fifo_count == '0);
    assign fifo_push         = keep_rsp & ~(bypass & bus.instr_ready);
    assign bus.instr_valid   = (fifo_count != '0) | bypass;
    assign bus.instr_out     = bypass ? bus.imem_rdata : fifo_head[INSTR_LEN+XLEN-1:XLEN];
    assign bus.instr_tag_out = bypass ? rsp_tag : fifo_head[XLEN-1:0];
`else
    assign fifo_push         = keep_rsp;
    assign bus.instr_valid   = (fifo_count != '0);
    assign bus.instr_out     = fifo_head[INSTR_LEN+XLEN-1:XLEN];
    assign bus.instr_tag_out = fifo_head[XLEN-1:0];
`endif

    ifu_fifo #(.W(INSTR_LEN + XLEN), .DEPTH(DEPTH)) u_out_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.pc_load),
        .push     (fifo_push),
        .push_dat ({bus.imem_rdata, rsp_tag}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );
endmodule
